// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: block geometry, padding constant, block-count
// helper and the padder state encoding.
package sha256_pkg;

   localparam int          BLOCK_WORDS = 16;
   localparam logic [31:0] PAD_WORD    = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      OFFER  = 2'd2,
      FINISH = 2'd3
   } padder_state_t;

   // Blocks needed for message + 0x80000000 word + 64-bit bit length.
   function automatic int num_blocks(input int n_words);
      return (n_words + 18) / BLOCK_WORDS;
   endfunction

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Bundle between the message padder, its word memory and the compression stage.
interface sha256_msg_padder_if;
   import sha256_pkg::*;

   // Block handshake: a block transfers on a rising clock edge where blk_valid
   // and blk_ready are both 1; once raised, blk_valid, blk_data and blk_last
   // hold until that transfer, and blk_ready alone never has an effect.
   logic                start;
   logic [15:0]         message_addr;
   logic [15:0]         mem_addr;
   logic [31:0]         mem_read_data;
   logic                blk_valid;
   logic                blk_ready;
   logic [511:0]        blk_data;
   logic                blk_last;
   logic                busy;
   logic                done;
   padder_state_t       dbg_state;

   modport master (
      input  start, message_addr, mem_read_data, blk_ready,
      output mem_addr, blk_valid, blk_data, blk_last, busy, done, dbg_state
   );

   modport slave (
      output start, message_addr, mem_read_data, blk_ready,
      input  mem_addr, blk_valid, blk_data, blk_last, busy, done, dbg_state
   );

endinterface

// File: rtl/sha256_msg_padder.sv
// Reads a fixed-length message from a synchronous word memory and offers it
// as SHA-256 padded 512-bit blocks, one block per valid/ready transfer.
module sha256_msg_padder
   import sha256_pkg::*;
#(
   parameter int NUM_OF_WORDS = 20
) (
   input  logic                clk,
   input  logic                reset,
   sha256_msg_padder_if.master bus
);

   localparam int          NUM_BLOCKS = num_blocks(NUM_OF_WORDS);
   localparam logic [16:0] MSG_WORDS  = 17'(NUM_OF_WORDS);
   localparam logic [12:0] LAST_BLK   = 13'(NUM_BLOCKS - 1);
   localparam logic [31:0] LEN_BITS   = 32'(NUM_OF_WORDS * 32);
   localparam logic [4:0]  FILL_END   = 5'd17;

   padder_state_t r_state, w_next_state;
   logic [4:0]    r_cnt;
   logic [12:0]   r_blk;
   logic [15:0]   r_base;
   logic [15:0]   r_mem_addr;
   logic [511:0]  r_blk_data;
   logic          r_blk_last;

   logic          w_handshake;
   logic          w_issue;
   logic          w_last_blk;
   logic [15:0]   w_iss_base;
   logic [16:0]   w_iss_g;
   logic [16:0]   w_wr_g;
   logic [3:0]    w_wr_slot;
   logic [31:0]   w_wr_word;

   // r_cnt counts FILL cycles: slot r_cnt is read, slot r_cnt-2 is written,
   // since the memory answers one cycle after the address register updates.
   assign w_handshake = (r_state == OFFER) && bus.blk_ready;
   assign w_wr_slot   = 4'(r_cnt - 5'd2);
   assign w_wr_g      = {r_blk, w_wr_slot};
   assign w_last_blk  = (r_blk == LAST_BLK);

   always_comb begin
      w_iss_base = r_base;
      w_iss_g    = {r_blk, r_cnt[3:0]};
      w_issue    = 1'b0;
      case (r_state)
         IDLE: begin
            w_iss_base = bus.message_addr;
            w_iss_g    = '0;
            w_issue    = bus.start;
         end
         FILL:    w_issue = (r_cnt < 5'd16);
         OFFER: begin
            w_iss_g = {r_blk + 13'd1, 4'd0};
            w_issue = w_handshake && !r_blk_last;
         end
         default: w_issue = 1'b0;
      endcase
      w_issue = w_issue && (w_iss_g < MSG_WORDS);
   end

   always_comb begin
      if (w_wr_g < MSG_WORDS)                      w_wr_word = bus.mem_read_data;
      else if (w_wr_g == MSG_WORDS)                w_wr_word = PAD_WORD;
      else if (w_last_blk && (w_wr_slot == 4'd15)) w_wr_word = LEN_BITS;
      else                                         w_wr_word = '0;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_next_state = FILL;
         FILL:    if (r_cnt == FILL_END) w_next_state = OFFER;
         OFFER:   if (w_handshake) w_next_state = r_blk_last ? FINISH : FILL;
         FINISH:  w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt      <= '0;
         r_blk      <= '0;
         r_base     <= '0;
         r_mem_addr <= '0;
         r_blk_data <= '0;
         r_blk_last <= 1'b0;
      end else begin
         if (w_issue) r_mem_addr <= w_iss_base + w_iss_g[15:0];
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_base <= bus.message_addr;
                  r_cnt  <= 5'd1;
               end
            end
            FILL: begin
               if (r_cnt >= 5'd2)
                  r_blk_data[10'd511 - {1'b0, w_wr_slot, 5'd0} -: 32] <= w_wr_word;
               if (r_cnt == FILL_END) begin
                  r_cnt      <= '0;
                  r_blk_last <= w_last_blk;
               end else begin
                  r_cnt <= r_cnt + 5'd1;
               end
            end
            OFFER: begin
               if (w_handshake) begin
                  r_blk <= r_blk + 13'd1;
                  r_cnt <= 5'd1;
               end
            end
            FINISH: begin
               r_blk      <= '0;
               r_blk_last <= 1'b0;
            end
            default: r_cnt <= '0;
         endcase
      end
   end

   assign bus.mem_addr  = r_mem_addr;
   assign bus.blk_valid = (r_state == OFFER);
   assign bus.blk_data  = r_blk_data;
   assign bus.blk_last  = r_blk_last;
   assign bus.busy      = (r_state != IDLE);
   assign bus.done      = (r_state == FINISH);
   assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: three instances (N = 20, 13, 14) share one
// stimulus stream and one word memory; a bit-level padding model predicts every block.
module tb_sha256_msg_padder;
  import sha256_pkg::*;

  localparam int NI = 3;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] message_addr;
  logic        blk_ready;
  logic [31:0] mem [0:65535];

  logic [15:0]   a_mem_addr [NI];
  logic          a_valid [NI];
  logic          a_last [NI];
  logic          a_busy [NI];
  logic          a_done [NI];
  logic [511:0]  a_data [NI];
  padder_state_t a_state [NI];

  int n_checks = 0;
  int n_errors = 0;

  logic [511:0] exp_q [NI][$];
  int           m_cnt [NI];
  bit           m_busy [NI];
  bit           m_done [NI];
  logic [511:0] acc_blk [NI][4];
  bit           acc_last [NI][4];
  int           acc_n [NI];
  int           done_cnt [NI];
  logic [15:0]  addr_q [$];

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT instances ----------------
  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int NW = (k == 0) ? 20 : ((k == 1) ? 13 : 14);
    sha256_msg_padder_if bus ();
    logic [31:0] rd;

    assign bus.start         = start;
    assign bus.message_addr  = message_addr;
    assign bus.blk_ready     = blk_ready;
    assign bus.mem_read_data = rd;

    always @(posedge clk) rd <= mem[bus.mem_addr];

    assign a_mem_addr[k] = bus.mem_addr;
    assign a_valid[k]    = bus.blk_valid;
    assign a_last[k]     = bus.blk_last;
    assign a_busy[k]     = bus.busy;
    assign a_done[k]     = bus.done;
    assign a_data[k]     = bus.blk_data;
    assign a_state[k]    = bus.dbg_state;

    sha256_msg_padder #(.NUM_OF_WORDS(NW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
    );
  end

  // ---------------- model helpers ----------------
  function automatic int n_of(input int k);
    case (k)
      0:       return 20;
      1:       return 13;
      default: return 14;
    endcase
  endfunction

  // Smallest number of 512-bit blocks holding n*32 message bits, one '1' bit and 64 length bits.
  function automatic int blocks_for(input int n);
    return (n * 32 + 1 + 64 + 511) / 512;
  endfunction

  function automatic logic [511:0] exp_block(input int n, input logic [15:0] a, input int b);
    logic [511:0] blk;
    logic [31:0]  w;
    int           g;
    int           nb;
    nb  = blocks_for(n);
    blk = '0;
    for (int s = 0; s < 16; s++) begin
      g = 16 * b + s;
      if (g < n)                w = mem[16'(a + 16'(g))];
      else if (g == n)          w = 32'h8000_0000;
      else if (g == 16*nb - 1)  w = 32'(n * 32);
      else                      w = 32'h0;
      blk = {blk[479:0], w};
    end
    return blk;
  endfunction

  function automatic logic [31:0] wd(input logic [511:0] b, input int s);
    return b[511 - 32*s -: 32];
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  initial begin : compare
    logic ev;
    int   n;
    for (int k = 0; k < NI; k++) begin
      m_cnt[k] = 0; m_busy[k] = 0; m_done[k] = 0; acc_n[k] = 0; done_cnt[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        if (reset) begin
          m_busy[k] = 0; m_done[k] = 0; m_cnt[k] = 0;
          exp_q[k].delete();
        end
        ev = m_busy[k] && (m_cnt[k] >= 17);
        check($sformatf("blk_valid[%0d]", k), a_valid[k], ev);
        check($sformatf("busy[%0d]", k), a_busy[k], m_busy[k] || m_done[k]);
        check($sformatf("done[%0d]", k), a_done[k], m_done[k]);
        if (a_done[k]) done_cnt[k]++;
        if (reset) begin
          check($sformatf("rst_data[%0d]", k), a_data[k], '0);
          check($sformatf("rst_addr[%0d]", k), a_mem_addr[k], 16'h0);
          check($sformatf("rst_last[%0d]", k), a_last[k], 1'b0);
          check($sformatf("rst_state[%0d]", k), a_state[k], IDLE);
        end
        if (ev && a_valid[k]) begin
          check($sformatf("blk_data[%0d]", k), a_data[k], exp_q[k][0]);
          check($sformatf("blk_last[%0d]", k), a_last[k], exp_q[k].size() == 1);
        end
        if (!reset) begin
          n = n_of(k);
          if (m_done[k]) begin
            m_done[k] = 0;
          end else if (!m_busy[k]) begin
            if (start) begin
              m_busy[k] = 1;
              m_cnt[k]  = 0;
              for (int b = 0; b < blocks_for(n); b++)
                exp_q[k].push_back(exp_block(n, message_addr, b));
            end
          end else if (m_cnt[k] < 17) begin
            m_cnt[k]++;
          end else if (blk_ready) begin
            if (acc_n[k] < 4) begin
              acc_blk[k][acc_n[k]]  = a_data[k];
              acc_last[k][acc_n[k]] = a_last[k];
              acc_n[k]++;
            end
            void'(exp_q[k].pop_front());
            if (exp_q[k].size() == 0) begin
              m_busy[k] = 0;
              m_done[k] = 1;
            end else begin
              m_cnt[k] = 0;
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_msg(input logic [15:0] a, input logic [31:0] base);
    for (int i = 0; i < 20; i++) mem[16'(a + 16'(i))] = base + 32'(i);
  endtask

  task automatic clear_log();
    for (int k = 0; k < NI; k++) begin
      acc_n[k]    = 0;
      done_cnt[k] = 0;
    end
  endtask

  task automatic pulse_start(input logic [15:0] a);
    @(posedge clk); #1;
    start        = 1'b1;
    message_addr = a;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int cyc;
    cyc = 0;
    while ((a_busy[0] || a_busy[1] || a_busy[2]) && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_timeout"}, cyc >= 300, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int          cyc;
    logic [511:0] d0;
    logic [15:0] ad0;
    logic [15:0] prev;

    reset        = 1'b1;
    start        = 1'b0;
    message_addr = 16'h0;
    blk_ready    = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Run 1: A=0x0040, words k+1, ready always high
    load_msg(16'h0040, 32'd1);
    clear_log();
    blk_ready = 1'b1;
    pulse_start(16'h0040);
    wait_idle("run1");
    check("n20_blocks", acc_n[0], 2);
    check("n20_b0_w0", wd(acc_blk[0][0], 0), 32'd1);
    check("n20_b0_w15", wd(acc_blk[0][0], 15), 32'd16);
    check("n20_b0_last", acc_last[0][0], 1'b0);
    check("n20_b1", acc_blk[0][1],
          {32'd17, 32'd18, 32'd19, 32'd20, 32'h8000_0000, {10{32'h0}}, 32'h0000_0280});
    check("n20_b1_last", acc_last[0][1], 1'b1);
    check("n13_blocks", acc_n[1], 1);
    check("n13_w12", wd(acc_blk[1][0], 12), 32'd13);
    check("n13_w13", wd(acc_blk[1][0], 13), 32'h8000_0000);
    check("n13_w14", wd(acc_blk[1][0], 14), 32'h0);
    check("n13_w15", wd(acc_blk[1][0], 15), 32'h0000_01A0);
    check("n13_last", acc_last[1][0], 1'b1);
    check("n14_blocks", acc_n[2], 2);
    check("n14_b0_w14", wd(acc_blk[2][0], 14), 32'h8000_0000);
    check("n14_b0_w15", wd(acc_blk[2][0], 15), 32'h0);
    check("n14_b1", acc_blk[2][1], {{15{32'h0}}, 32'h0000_01C0});
    for (int k = 0; k < NI; k++) check($sformatf("done_once[%0d]", k), done_cnt[k], 1);

    // Run 2: block 0 stalled for 5 cycles
    load_msg(16'h0100, 32'hA000_0000);
    clear_log();
    blk_ready = 1'b0;
    pulse_start(16'h0100);
    cyc = 0;
    while (!a_valid[0] && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("lat_first", cyc, 17);
    d0  = a_data[0];
    ad0 = a_mem_addr[0];
    check("stall_w0", wd(d0, 0), 32'hA000_0000);
    repeat (5) begin
      @(posedge clk); #1;
      check("stall_data", a_data[0], d0);
      check("stall_addr", a_mem_addr[0], ad0);
      check("stall_valid", a_valid[0], 1'b1);
    end
    blk_ready = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (!a_valid[0] && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("lat_next", cyc, 17);
    wait_idle("run2");
    check("run2_blocks", acc_n[0], 2);

    // Run 3: address wrap from 0xFFFA
    load_msg(16'hFFFA, 32'h5000_0000);
    clear_log();
    addr_q.delete();
    prev = a_mem_addr[0];
    pulse_start(16'hFFFA);
    cyc = 0;
    while (a_busy[0] && cyc < 300) begin
      if (a_mem_addr[0] != prev) begin
        addr_q.push_back(a_mem_addr[0]);
        prev = a_mem_addr[0];
      end
      @(posedge clk); #1;
      cyc++;
    end
    wait_idle("run3");
    check("wrap_count", addr_q.size(), 20);
    for (int i = 0; i < 20; i++)
      if (i < addr_q.size()) check($sformatf("wrap_addr%0d", i), addr_q[i], 16'(16'hFFFA + 16'(i)));
    if (addr_q.size() == 20) check("wrap_last", addr_q[19], 16'h000D);
    check("wrap_b1_w3", wd(acc_blk[0][1], 3), 32'h5000_0013);

    // Run 4: stray start mid-message, then reset during block 1 fill
    load_msg(16'h0200, 32'h7000_0000);
    clear_log();
    pulse_start(16'h0200);
    repeat (5) @(posedge clk);
    #1;
    start        = 1'b1;
    message_addr = 16'h0300;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (acc_n[0] < 1 && cyc < 60) begin @(posedge clk); #1; cyc++; end
    check("run4_hs_timeout", cyc >= 60, 1'b0);
    check("run4_b0_w5", wd(acc_blk[0][0], 5), 32'h7000_0005);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("midrst_valid", a_valid[0], 1'b0);
    check("midrst_busy", a_busy[0], 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    load_msg(16'h0200, 32'hC000_0000);
    clear_log();
    pulse_start(16'h0200);
    wait_idle("run4");
    check("fresh_blocks", acc_n[0], 2);
    check("fresh_w0", wd(acc_blk[0][0], 0), 32'hC000_0000);
    check("fresh_w15", wd(acc_blk[0][0], 15), 32'hC000_000F);
    check("fresh_b1_w3", wd(acc_blk[0][1], 3), 32'hC000_0013);
    check("fresh_n14_w13", wd(acc_blk[2][0], 13), 32'hC000_000D);
    check("fresh_done", done_cnt[0], 1);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/sha256_msg_padder.md
SHA256_MSG_PADDER -- requirements
Module: sha256_msg_padder

Interface
REQ-001 NUM_OF_WORDS, default 20, message length in 32-bit words; legal range 1..65535.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  request to pad the message; sampled only in IDLE.
REQ-005 message_addr  in  16  word address of message word 0.
REQ-006 mem_addr  out  16  read address to synchronous word memory, which returns data one cycle later.
REQ-007 mem_read_data  in  32  read data for the address presented on the previous cycle.
REQ-008 blk_valid  out  1  blk_data holds a complete 512-bit padded block.
REQ-009 blk_ready  in  1  the downstream compression stage accepts the block when blk_valid and blk_ready are both 1.
REQ-010 blk_data  out  512  padded block; word 0 is in [511:480], word 15 is in [31:0].
REQ-011 blk_last  out  1  qualifies blk_valid; 1 on the final block of the message.
REQ-012 busy  out  1  1 in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse after the final block is accepted.

Function
REQ-014 The FSM SHALL have the states IDLE, FILL, OFFER and FINISH.
- IDLE to FILL on start.
- FILL to OFFER when slot 15 is written.
- OFFER to FILL on a handshake with blk_last=0.
- OFFER to FINISH on a handshake with blk_last=1.
- FINISH to IDLE after one cycle.
REQ-015 The block count SHALL be floor((NUM_OF_WORDS+18)/16), so that message + 0x80000000 + 64-bit length fits (N=13 gives 1 block; N=14 and N=20 give 2).
REQ-016 Global word index g = 16*block + slot. Slot content:
- g < N: mem[message_addr+g];
- g == N: 32'h80000000;
- last block, slot 14: 32'h00000000;
- last block, slot 15: N*32 (low half of the 64-bit bit length);
- all other slots: 0.
REQ-017 Address generation:
- mem_addr = message_addr + g, computed modulo 2^16 (wraps at 16'hFFFF);
- addresses are issued one word per cycle, pipelined, while g < N;
- in all other cycles mem_addr holds its last value.
REQ-018 FILL SHALL write exactly one slot per cycle; pad slots need no memory access.
REQ-019 Latency: blk_valid SHALL rise exactly 17 cycles after start is sampled, or 17 cycles after the previous block's handshake.
REQ-020 While blk_valid=1 and blk_ready=0, blk_data and blk_last SHALL hold stable and no memory address SHALL advance.
REQ-021 blk_valid SHALL fall on the cycle after a handshake and not assert again until the next block is complete.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 blk_ready asserted while blk_valid=0 SHALL have no effect.
REQ-024 done SHALL pulse in FINISH only; busy SHALL be 0 in the cycle after FINISH.

Reset
REQ-025 On reset:
- state = IDLE;
- blk_valid, blk_last, busy, done = 0;
- blk_data = 0;
- mem_addr = 0;
- block and slot counters = 0.
REQ-026 Reset asserted mid-operation SHALL abandon the message immediately; no partial block is ever offered after reset.

Structure
REQ-027 Package sha256_pkg SHALL hold:
- BLOCK_WORDS = 16;
- PAD_WORD = 32'h80000000;
- the num_blocks function;
- the state enum typedef.
The compression stage SHALL share this package.
REQ-028 No sub-module is required; the 16x32 block register, slot counter, block counter and FSM stay in one module.

Verification
REQ-029 N=20, mem[A+k]=k+1, A=16'h0040, blk_ready=1:
- block 0 = words 1..16, blk_last=0;
- block 1 = 17,18,19,20, 0x80000000, ten zeros, 0x00000280, blk_last=1;
- done pulses once.
REQ-030 N=13: a single block; slot 13 = 0x80000000, slot 14 = 0, slot 15 = 0x000001A0, blk_last=1.
REQ-031 N=14:
- block 0 slot 14 = 0x80000000, slot 15 = 0;
- block 1 slots 0..14 = 0, slot 15 = 0x000001C0.
REQ-032 N=20, blk_ready held low for 5 cycles on block 0: blk_data is unchanged across all 5 cycles, mem_addr is frozen, and block 1 is offered 17 cycles after the handshake.
REQ-033 N=20, message_addr=16'hFFFA: the read addresses wrap to 16'h0000..16'h000D.
REQ-034 Reset asserted during FILL of block 1:
- blk_valid = 0 and busy = 0 next cycle;
- a new start then produces a correct block 0 with no stale data.
- A start pulsed mid-message is ignored.
